alarm_set_controller: RTL and testbench
=======================================

# alarm_set_controller

Button-driven configuration and sequencing controller for the 24-hour alarm clock datapath. Turns single-cycle debounced button pulses into digit-by-digit editing of the clock time or alarm time, then drives the datapath's load_time/load_alarm/STOP_alarm inputs. Each load or stop level is held stable long enough for the datapath's 1 s slow-clock domain to capture it. Also schedules snooze: it silences the alarm and reprograms the alarm to current time + SNOOZE_MIN.

## Interface
- HOLD_CYCLES, 110_000_000: cycles load/stop levels are held; must exceed one slow-clock period (use 4 in simulation).
- SNOOZE_MIN, 5: snooze offset in minutes, legal 1..59.
- CNT_W, 27: width of hold counter, must hold HOLD_CYCLES.

Ports:
- clock  in  1  100 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- btn_mode, btn_next, btn_inc, btn_stop, btn_snooze  in  1 each  one-cycle pulses, already debounced and edge-detected.
- Alarm  in  1  alarm output from datapath.
- cur_hour1 in 2, cur_hour0 / cur_min1 / cur_min0 in 4  current time digits from datapath.
- hour_in1 out 2, hour_in0 / minute_in1 / minute_in0 out 4  digits to datapath, registered.
- load_time, load_alarm, STOP_alarm  out  1  registered level controls to datapath.
- mode_out  out  2  0=IDLE, 1=EDIT_TIME, 2=EDIT_ALARM, 3=BUSY (COMMIT/STOP/SNOOZE).
- digit_sel  out  2  digit being edited: 0=H1, 1=H0, 2=M1, 3=M0 (for display blink).

## Operation
- Internal alarm shadow register holds the last committed alarm value. Reset value is 24:00, matching the datapath's "never matches" reset alarm.
- States: IDLE, EDIT_TIME, EDIT_ALARM, COMMIT_T, COMMIT_A, STOP, SNOOZE.
- IDLE transitions, priority stop > snooze > mode:
  - btn_stop with Alarm=1 -> STOP.
  - btn_snooze with Alarm=1 -> SNOOZE.
  - btn_mode -> EDIT_TIME; edit regs preloaded from cur_* digits; digit_sel=0.
  - btn_stop/btn_snooze with Alarm=0 are ignored.
- EDIT_TIME / EDIT_ALARM, priority mode > next > inc:
  - btn_mode from EDIT_TIME -> EDIT_ALARM; edit regs preloaded from shadow, with 24:00 mapped to 00:00; digit_sel=0.
  - btn_mode from EDIT_ALARM -> IDLE, edit abandoned.
  - btn_next: digit_sel+1. On digit_sel=3 it goes to COMMIT_T or COMMIT_A instead.
  - btn_inc increments the selected digit with wrap:
    - H1: 0..2.
    - H0: 0..9, or 0..3 when H1=2.
    - M1: 0..5.
    - M0: 0..9.
  - If H1 becomes 2 while H0>3, H0 is forced to 0 in the same cycle.
- COMMIT_T / COMMIT_A:
  - load_time (or load_alarm) =1 for exactly HOLD_CYCLES cycles, then IDLE.
  - hour_in*/minute_in* frozen for the whole hold.
  - COMMIT_A copies the edit regs into the shadow on entry.
- STOP: STOP_alarm=1 for HOLD_CYCLES cycles, then IDLE.
- SNOOZE:
  - On entry, compute the target: m = cur_min1*10 + cur_min0 + SNOOZE_MIN.
    - If m ≥ 60: m -= 60 and h = hour+1, with 24 wrapping to 0.
    - Split h and m into digits; load them into the output regs and the shadow.
  - Then STOP_alarm=1 and load_alarm=1 together for HOLD_CYCLES cycles, then IDLE.
- All buttons are ignored in COMMIT_*, STOP and SNOOZE.
- Outside COMMIT/SNOOZE, hour_in*/minute_in* show the edit regs. Load outputs are low, so the datapath ignores them.

## Timing
- All outputs are registered. A button sampled at edge t changes state and outputs at edge t (visible after t). There is no combinational path from inputs to outputs.
- Load/stop rises on the first cycle in the COMMIT/STOP/SNOOZE state and falls after HOLD_CYCLES cycles.
- Digit outputs are valid on the same cycle the load rises and remain stable until after it falls.
- Reset values: all digit outputs 0, load_time=0, load_alarm=0, STOP_alarm=0, mode_out=0, digit_sel=0, state IDLE, shadow 24:00, hold counter 0.
- Reset mid-hold drops every level output on the reset assertion itself, with no wait for a clock edge.
- Snooze arithmetic uses at least 7-bit intermediates; 23:58 + 5 -> 00:03.
- Alarm may rise while editing: no effect until the controller returns to IDLE. A btn_stop/btn_snooze pulse received during editing is ignored, not queued.

## Test plan
Bench settings: HOLD_CYCLES=4, SNOOZE_MIN=5.
- Reset mid-COMMIT_T -> load_time drops immediately; all outputs 0; mode_out=0.
- mode, then 4×next with cur time 07:30 -> load_time high for exactly 4 cycles; digits 0,7,3,0 stable throughout; mode_out returns to 0.
- mode, mode, then inc×3 on H1 -> H1 sequence 1,2,0. With H0=7, H1→2 forces H0=0. Commit 20:00 -> load_alarm 4 cycles; shadow = 20:00.
- Alarm=1, cur 23:58, btn_snooze -> STOP_alarm and load_alarm both high 4 cycles; digits 0,0,0,3.
- Alarm=1, btn_stop and btn_snooze in the same cycle -> STOP only; load_alarm stays 0.
- btn_next and btn_inc in the same cycle while editing M0=9 -> digit_sel advances; M0 unchanged.

Source files
------------

// File: rtl/alarm_set_controller.sv
// Button-driven editor/sequencer for the alarm clock datapath: digit editing of
// time and alarm, held load/stop levels for the slow-clock domain, and snooze.
module alarm_set_controller #(
    parameter int HOLD_CYCLES = 110_000_000,
    parameter int SNOOZE_MIN  = 5,
    parameter int CNT_W       = 27
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic       btn_stop,
    input  logic       btn_snooze,
    input  logic       Alarm,
    input  logic [1:0] cur_hour1,
    input  logic [3:0] cur_hour0,
    input  logic [3:0] cur_min1,
    input  logic [3:0] cur_min0,
    output logic [1:0] hour_in1,
    output logic [3:0] hour_in0,
    output logic [3:0] minute_in1,
    output logic [3:0] minute_in0,
    output logic       load_time,
    output logic       load_alarm,
    output logic       STOP_alarm,
    output logic [1:0] mode_out,
    output logic [1:0] digit_sel
);

    typedef enum logic [2:0] {
        S_IDLE, S_EDIT_T, S_EDIT_A, S_COMMIT_T, S_COMMIT_A, S_STOP, S_SNOOZE
    } state_t;

    localparam logic [6:0]       SNZ7 = 7'(SNOOZE_MIN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       h1_q, h1_d, sh_h1_q, sh_h1_d, sel_q, sel_d, mode_q, mode_d;
    logic [3:0]       h0_q, h0_d, m1_q, m1_d, m0_q, m0_d;
    logic [3:0]       sh_h0_q, sh_h0_d, sh_m1_q, sh_m1_d, sh_m0_q, sh_m0_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lt_q, lt_d, la_q, la_d, st_q, st_d;

    logic [6:0] hr7, mn7;
    logic [1:0] snz_h1;
    logic [3:0] snz_h0, snz_m1, snz_m0;

    // Snooze target; digits are recovered with 4-bit arithmetic since ones < 10.
    always_comb begin
        hr7 = {5'd0, cur_hour1} * 7'd10 + {3'd0, cur_hour0};
        mn7 = {3'd0, cur_min1} * 7'd10 + {3'd0, cur_min0} + SNZ7;
        if (mn7 >= 7'd60) begin
            mn7 = mn7 - 7'd60;
            hr7 = (hr7 >= 7'd23) ? 7'd0 : hr7 + 7'd1;
        end
        snz_h1 = (hr7 >= 7'd20) ? 2'd2 : (hr7 >= 7'd10) ? 2'd1 : 2'd0;
        snz_h0 = hr7[3:0] - {2'd0, snz_h1} * 4'd10;
        snz_m1 = (mn7 >= 7'd50) ? 4'd5 : (mn7 >= 7'd40) ? 4'd4 : (mn7 >= 7'd30) ? 4'd3 :
                 (mn7 >= 7'd20) ? 4'd2 : (mn7 >= 7'd10) ? 4'd1 : 4'd0;
        snz_m0 = mn7[3:0] - snz_m1 * 4'd10;
    end

    always_comb begin
        state_d = state_q;
        h1_d    = h1_q;
        h0_d    = h0_q;
        m1_d    = m1_q;
        m0_d    = m0_q;
        sh_h1_d = sh_h1_q;
        sh_h0_d = sh_h0_q;
        sh_m1_d = sh_m1_q;
        sh_m0_d = sh_m0_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (btn_stop && Alarm) begin
                    state_d = S_STOP;
                end else if (btn_snooze && Alarm) begin
                    state_d = S_SNOOZE;
                    h1_d    = snz_h1;
                    h0_d    = snz_h0;
                    m1_d    = snz_m1;
                    m0_d    = snz_m0;
                    sh_h1_d = snz_h1;
                    sh_h0_d = snz_h0;
                    sh_m1_d = snz_m1;
                    sh_m0_d = snz_m0;
                end else if (btn_mode) begin
                    state_d = S_EDIT_T;
                    sel_d   = 2'd0;
                    h1_d    = cur_hour1;
                    h0_d    = cur_hour0;
                    m1_d    = cur_min1;
                    m0_d    = cur_min0;
                end
            end
            S_EDIT_T, S_EDIT_A: begin
                if (btn_mode) begin
                    sel_d = 2'd0;
                    if (state_q == S_EDIT_T) begin
                        state_d = S_EDIT_A;
                        // 24:00 is the "no alarm" marker; edit it as 00:00
                        if (sh_h1_q == 2'd2 && sh_h0_q == 4'd4) begin
                            h1_d = 2'd0;
                            h0_d = 4'd0;
                        end else begin
                            h1_d = sh_h1_q;
                            h0_d = sh_h0_q;
                        end
                        m1_d = sh_m1_q;
                        m0_d = sh_m0_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (btn_next) begin
                    if (sel_q == 2'd3) begin
                        sel_d = 2'd0;
                        if (state_q == S_EDIT_T) begin
                            state_d = S_COMMIT_T;
                        end else begin
                            state_d = S_COMMIT_A;
                            sh_h1_d = h1_q;
                            sh_h0_d = h0_q;
                            sh_m1_d = m1_q;
                            sh_m0_d = m0_q;
                        end
                    end else begin
                        sel_d = sel_q + 2'd1;
                    end
                end else if (btn_inc) begin
                    case (sel_q)
                        2'd0: begin
                            h1_d = (h1_q >= 2'd2) ? 2'd0 : h1_q + 2'd1;
                            if (h1_d == 2'd2 && h0_q > 4'd3) h0_d = 4'd0;
                        end
                        2'd1: h0_d = (h0_q >= ((h1_q == 2'd2) ? 4'd3 : 4'd9)) ? 4'd0 : h0_q + 4'd1;
                        2'd2: m1_d = (m1_q >= 4'd5) ? 4'd0 : m1_q + 4'd1;
                        default: m0_d = (m0_q >= 4'd9) ? 4'd0 : m0_q + 4'd1;
                    endcase
                end
            end
            default: begin
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

        // Levels follow the next state so they rise on entry and fall on exit.
        lt_d = (state_d == S_COMMIT_T);
        la_d = (state_d == S_COMMIT_A) || (state_d == S_SNOOZE);
        st_d = (state_d == S_STOP) || (state_d == S_SNOOZE);
        case (state_d)
            S_IDLE:   mode_d = 2'd0;
            S_EDIT_T: mode_d = 2'd1;
            S_EDIT_A: mode_d = 2'd2;
            default:  mode_d = 2'd3;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            h1_q    <= '0;
            h0_q    <= '0;
            m1_q    <= '0;
            m0_q    <= '0;
            sh_h1_q <= 2'd2;
            sh_h0_q <= 4'd4;
            sh_m1_q <= '0;
            sh_m0_q <= '0;
            sel_q   <= '0;
            mode_q  <= '0;
            cnt_q   <= '0;
            lt_q    <= 1'b0;
            la_q    <= 1'b0;
            st_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            h1_q    <= h1_d;
            h0_q    <= h0_d;
            m1_q    <= m1_d;
            m0_q    <= m0_d;
            sh_h1_q <= sh_h1_d;
            sh_h0_q <= sh_h0_d;
            sh_m1_q <= sh_m1_d;
            sh_m0_q <= sh_m0_d;
            sel_q   <= sel_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            lt_q    <= lt_d;
            la_q    <= la_d;
            st_q    <= st_d;
        end
    end

    assign hour_in1   = h1_q;
    assign hour_in0   = h0_q;
    assign minute_in1 = m1_q;
    assign minute_in0 = m0_q;
    assign load_time  = lt_q;
    assign load_alarm = la_q;
    assign STOP_alarm = st_q;
    assign mode_out   = mode_q;
    assign digit_sel  = sel_q;

endmodule

// File: tb/tb_alarm_set_controller.sv
// Directed-vector bench for alarm_set_controller with HOLD_CYCLES=4, SNOOZE_MIN=5.
module tb_alarm_set_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       btn_mode, btn_next, btn_inc, btn_stop, btn_snooze, Alarm;
    logic [1:0] cur_hour1;
    logic [3:0] cur_hour0, cur_min1, cur_min0;
    logic [1:0] hour_in1, mode_out, digit_sel;
    logic [3:0] hour_in0, minute_in1, minute_in0;
    logic       load_time, load_alarm, STOP_alarm;

    int n_vec = 0;
    int n_err = 0;

    wire [13:0] digs = {hour_in1, hour_in0, minute_in1, minute_in0};
    wire [2:0]  lvls = {load_time, load_alarm, STOP_alarm};

    alarm_set_controller #(.HOLD_CYCLES(4), .SNOOZE_MIN(5), .CNT_W(27)) dut (
        .clock(clock), .reset(reset),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
        .btn_stop(btn_stop), .btn_snooze(btn_snooze), .Alarm(Alarm),
        .cur_hour1(cur_hour1), .cur_hour0(cur_hour0),
        .cur_min1(cur_min1), .cur_min0(cur_min0),
        .hour_in1(hour_in1), .hour_in0(hour_in0),
        .minute_in1(minute_in1), .minute_in0(minute_in0),
        .load_time(load_time), .load_alarm(load_alarm), .STOP_alarm(STOP_alarm),
        .mode_out(mode_out), .digit_sel(digit_sel)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One-cycle button pulse: {mode, next, inc, stop, snooze}
    task automatic press(input logic [4:0] b);
        {btn_mode, btn_next, btn_inc, btn_stop, btn_snooze} = b;
        tick();
        {btn_mode, btn_next, btn_inc, btn_stop, btn_snooze} = 5'b0;
    endtask

    task automatic set_cur(input logic [1:0] h1, input logic [3:0] h0,
                           input logic [3:0] m1, input logic [3:0] m0);
        cur_hour1 = h1; cur_hour0 = h0; cur_min1 = m1; cur_min0 = m0;
    endtask

    // Called right after the edge that entered a busy state; counts busy cycles.
    task automatic run_hold(input string tag, input logic [13:0] exp_dig, input logic [2:0] exp_lvl);
        int n;
        n = 0;
        while (mode_out == 2'd3 && n < 20) begin
            check({tag, "_lvl"}, 32'(lvls), 32'(exp_lvl));
            check({tag, "_dig"}, 32'(digs), 32'(exp_dig));
            n++;
            tick();
        end
        check({tag, "_len"}, n, 4);
        check({tag, "_lvl_off"}, 32'(lvls), 0);
        check({tag, "_mode_idle"}, 32'(mode_out), 0);
    endtask

    localparam logic [4:0] B_MODE = 5'b10000, B_NEXT = 5'b01000, B_INC = 5'b00100,
                           B_STOP = 5'b00010, B_SNZ = 5'b00001;

    initial begin
        reset = 1'b1;
        {btn_mode, btn_next, btn_inc, btn_stop, btn_snooze} = 5'b0;
        Alarm = 1'b0;
        set_cur(2'd0, 4'd7, 4'd3, 4'd0);
        tick(); tick();
        check("rst_digits", 32'(digs), 0);
        check("rst_levels", 32'(lvls), 0);
        check("rst_mode", 32'(mode_out), 0);
        reset = 1'b0;
        tick();

        // Commit current time 07:30
        press(B_MODE);
        check("et_mode", 32'(mode_out), 1);
        check("et_preload", 32'(digs), 32'({2'd0, 4'd7, 4'd3, 4'd0}));
        check("et_sel0", 32'(digit_sel), 0);
        press(B_NEXT); press(B_NEXT); press(B_NEXT);
        check("et_sel3", 32'(digit_sel), 3);
        press(B_NEXT);
        run_hold("commit_t", {2'd0, 4'd7, 4'd3, 4'd0}, 3'b100);

        // Reset in the middle of a hold must drop levels without a clock edge
        press(B_MODE);
        press(B_NEXT); press(B_NEXT); press(B_NEXT); press(B_NEXT);
        tick();
        check("pre_rst_lt", 32'(load_time), 1);
        #1 reset = 1'b1;
        #1;
        check("async_rst_lt", 32'(load_time), 0);
        check("async_rst_mode", 32'(mode_out), 0);
        check("async_rst_dig", 32'(digs), 0);
        tick();
        reset = 1'b0;
        tick();

        // H1 increments, H0 forced when H1 reaches 2, H0 wraps at 3
        press(B_MODE);
        press(B_INC);
        check("h1_inc1", 32'(digs), 32'({2'd1, 4'd7, 4'd3, 4'd0}));
        press(B_INC);
        check("h1_inc2_force", 32'(digs), 32'({2'd2, 4'd0, 4'd3, 4'd0}));
        press(B_NEXT);
        press(B_INC); press(B_INC); press(B_INC);
        check("h0_max3", 32'(hour_in0), 3);
        press(B_INC);
        check("h0_wrap3", 32'(hour_in0), 0);

        // Alarm edit: 24:00 shadow appears as 00:00; H1 sequence 1,2,0
        press(B_MODE);
        check("ea_mode", 32'(mode_out), 2);
        check("ea_preload", 32'(digs), 0);
        press(B_INC);
        check("ea_h1_1", 32'(hour_in1), 1);
        press(B_INC);
        check("ea_h1_2", 32'(hour_in1), 2);
        press(B_INC);
        check("ea_h1_0", 32'(hour_in1), 0);
        press(B_INC); press(B_INC);
        press(B_NEXT); press(B_NEXT); press(B_NEXT); press(B_NEXT);
        run_hold("commit_a", {2'd2, 4'd0, 4'd0, 4'd0}, 3'b010);
        press(B_MODE); press(B_MODE);
        check("shadow_2000", 32'(digs), 32'({2'd2, 4'd0, 4'd0, 4'd0}));
        press(B_MODE);

        // Stop with no alarm is ignored
        press(B_STOP);
        check("stop_no_alarm", 32'(mode_out), 0);

        // Snooze from 23:58 wraps to 00:03
        Alarm = 1'b1;
        set_cur(2'd2, 4'd3, 4'd5, 4'd8);
        press(B_SNZ);
        run_hold("snooze", {2'd0, 4'd0, 4'd0, 4'd3}, 3'b011);
        press(B_MODE); press(B_MODE);
        check("shadow_0003", 32'(digs), 32'({2'd0, 4'd0, 4'd0, 4'd3}));
        press(B_STOP);
        check("stop_in_edit", 32'(mode_out), 2);
        press(B_MODE);
        tick();
        check("stop_not_queued", 32'(mode_out), 0);

        // Stop wins over snooze
        press(B_STOP | B_SNZ);
        run_hold("stop_prio", {2'd0, 4'd0, 4'd0, 4'd3}, 3'b001);
        Alarm = 1'b0;

        // next beats inc; M0 wraps 9 -> 0
        set_cur(2'd0, 4'd7, 4'd3, 4'd9);
        press(B_MODE);
        press(B_NEXT); press(B_NEXT);
        press(B_NEXT | B_INC);
        check("next_over_inc_sel", 32'(digit_sel), 3);
        check("next_over_inc_dig", 32'(digs), 32'({2'd0, 4'd7, 4'd3, 4'd9}));
        press(B_INC);
        check("m0_wrap", 32'(minute_in0), 0);
        press(B_NEXT | B_INC);
        run_hold("commit_t2", {2'd0, 4'd7, 4'd3, 4'd0}, 3'b100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
